// File: rtl/axis_detector_run_ctrl_if.sv
// Stream bundle shared by the reader-side input and the DMA-side output of
// the detector run controller.
interface axis_detector_run_ctrl_if #(
  parameter int DATA_WIDTH = 128
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input  tready);
  modport slave  (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/axis_detector_run_ctrl.sv
// Run controller for the coincidence detector reader: latches the run
// configuration, sequences the reader through reset/arm/run/drain, applies a
// per-event holdoff and buffers accepted events in a FWFT FIFO toward a
// back-pressured consumer. Accepted/dropped counts and state go out on sts_data.
module axis_detector_run_ctrl #(
  parameter int FIFO_ADDR_WIDTH = 2,
  parameter int ARM_CYCLES      = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [95:0]              cfg_data,
  input  logic                     start,
  input  logic                     stop,
  output logic [10:0]              det_cfg_data,
  output logic                     det_resetn,
  axis_detector_run_ctrl_if.slave  s_axis,
  axis_detector_run_ctrl_if.master m_axis,
  output logic [95:0]              sts_data
);

  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Control state
  state_t             r_state;
  logic [ARM_W-1:0]   r_arm_cnt;
  logic [15:0]        r_cfg_holdoff;
  logic [31:0]        r_cfg_max;
  logic [31:0]        r_cfg_dur;
  logic [10:0]        r_det_cfg;
  logic               r_det_resetn;
  logic [31:0]        r_elapsed;
  logic [15:0]        r_holdoff_cnt;
  logic [31:0]        r_accepted;
  logic [31:0]        r_dropped;
  logic [95:0]        r_sts;

  // FIFO state
  logic [127:0]               r_mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] r_wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] r_rd_ptr;
  logic [FIFO_ADDR_WIDTH:0]   r_count;

  logic        w_full;
  logic        w_eligible;
  logic        w_push;
  logic        w_drop;
  logic        w_pop;
  logic        w_arm_done;
  logic        w_exit;
  logic [31:0] w_accepted_nxt;
  logic [31:0] w_dropped_nxt;
  logic        w_unused_cfg;

  // Reserved configuration bits are intentionally not consumed.
  assign w_unused_cfg = ^cfg_data[15:11];

  // The reader has no backpressure; its event strobe is always taken.
  assign s_axis.tready = 1'b1;

  assign w_full     = (r_count == (FIFO_ADDR_WIDTH+1)'(DEPTH));
  assign w_eligible = (r_state == S_RUN) && s_axis.tvalid && (r_holdoff_cnt == 16'd0);
  assign w_push     = w_eligible && !w_full;
  assign w_drop     = w_eligible && w_full;
  assign w_pop      = m_axis.tvalid && m_axis.tready;
  assign w_arm_done = (r_arm_cnt == ARM_W'(ARM_CYCLES - 1));

  assign w_accepted_nxt = (w_push && r_accepted != 32'hFFFF_FFFF) ? r_accepted + 32'd1 : r_accepted;
  assign w_dropped_nxt  = (w_drop && r_dropped  != 32'hFFFF_FFFF) ? r_dropped  + 32'd1 : r_dropped;

  // The max-event limit compares against the count including this cycle's
  // push so the run ends right after the last wanted event.
  assign w_exit = stop
               || ((r_cfg_dur != 32'd0) && (r_elapsed == r_cfg_dur - 32'd1))
               || ((r_cfg_max != 32'd0) && (w_accepted_nxt == r_cfg_max));

  // Run sequencer: configuration latch, reader control and run counters.
  // NOTE: every register in clocked logic uses <= so all flops update from the
  // same pre-edge values regardless of statement order.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state       <= S_IDLE;
      r_arm_cnt     <= '0;
      r_cfg_holdoff <= '0;
      r_cfg_max     <= '0;
      r_cfg_dur     <= '0;
      r_det_cfg     <= '0;
      r_det_resetn  <= 1'b0;
      r_elapsed     <= '0;
      r_holdoff_cnt <= '0;
      r_accepted    <= '0;
      r_dropped     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_det_resetn <= 1'b0;
          if (start) begin
            r_cfg_holdoff <= cfg_data[31:16];
            r_cfg_max     <= cfg_data[63:32];
            r_cfg_dur     <= cfg_data[95:64];
            r_det_cfg     <= cfg_data[10:0];
            r_elapsed     <= '0;
            r_holdoff_cnt <= '0;
            r_accepted    <= '0;
            r_dropped     <= '0;
            r_arm_cnt     <= '0;
            r_det_resetn  <= 1'b1;
            r_state       <= S_ARM;
          end
        end
        S_ARM: begin
          if (w_arm_done) begin
            r_state <= S_RUN;
          end else begin
            r_arm_cnt <= r_arm_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (r_elapsed != 32'hFFFF_FFFF) begin
            r_elapsed <= r_elapsed + 32'd1;
          end
          r_accepted <= w_accepted_nxt;
          r_dropped  <= w_dropped_nxt;
          if (w_push) begin
            r_holdoff_cnt <= r_cfg_holdoff;
          end else if (r_holdoff_cnt != 16'd0) begin
            r_holdoff_cnt <= r_holdoff_cnt - 16'd1;
          end
          if (w_exit) begin
            r_det_resetn <= 1'b0;
            r_state      <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_count == '0) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage write.
  // NOTE: the data array has no reset; emptiness is tracked by the pointers and
  // count, so resetting the storage would only cost routing.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_axis.tdata;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally modulo depth.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Status snapshot, one cycle behind the counters it reports.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_sts <= '0;
    end else begin
      r_sts <= {30'd0, r_state, r_dropped, r_accepted};
    end
  end

  assign m_axis.tdata  = r_mem[r_rd_ptr];
  assign m_axis.tvalid = (r_count != '0);
  assign det_cfg_data  = r_det_cfg;
  assign det_resetn    = r_det_resetn;
  assign sts_data      = r_sts;

endmodule
